// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32I width codes, FSM states,
// error causes, store strobe bases and the store lane replication helper.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  localparam logic [3:0] STRB_B = 4'b0001;
  localparam logic [3:0] STRB_H = 4'b0011;
  localparam logic [3:0] STRB_W = 4'b1111;

  typedef enum logic [1:0] {IDLE, REQ, WB, ERR} lsu_state_e;

  typedef enum logic [1:0] {ERR_NONE, ERR_MISALIGN, ERR_ILLEGAL, ERR_BUS} lsu_err_e;

  // Size code is funct3[1:0]: 0 byte, 1 half, otherwise word.
  function automatic logic [31:0] replicate_store(input logic [1:0] size,
                                                  input logic [31:0] d);
    case (size)
      2'd0:    return {4{d[7:0]}};
      2'd1:    return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

endpackage

// File: rtl/load_align.sv
// Extracts the addressed byte/half/word from a returned memory word and
// sign- or zero-extends it according to the RV32I load width code.
module load_align
  import lsu_pkg::*;
(
  input  logic [31:0] i_mem_rdata,
  input  logic [1:0]  i_addr_lo,
  input  logic [2:0]  i_funct3,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    case (i_addr_lo)
      2'd0:    w_byte = i_mem_rdata[7:0];
      2'd1:    w_byte = i_mem_rdata[15:8];
      2'd2:    w_byte = i_mem_rdata[23:16];
      default: w_byte = i_mem_rdata[31:24];
    endcase
  end

  assign w_half = i_addr_lo[1] ? i_mem_rdata[31:16] : i_mem_rdata[15:0];

  always_comb begin
    case (i_funct3)
      F3_B:    o_data = {{24{w_byte[7]}}, w_byte};
      F3_H:    o_data = {{16{w_half[15]}}, w_half};
      F3_BU:   o_data = {24'h0, w_byte};
      F3_HU:   o_data = {16'h0, w_half};
      default: o_data = i_mem_rdata;
    endcase
  end

endmodule

// File: rtl/lsu_writeback.sv
// Multi-cycle load/store unit: accepts one op at a time, runs req/ack with data
// memory and writes aligned load data to the register file.
module lsu_writeback
  import lsu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        ready,
  input  logic        is_load,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  input  logic [4:0]  rd,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic [4:0]  wright_reg,
  output logic [31:0] wright_data,
  output logic        wright_en,
  output logic        done,
  output logic        misalign_err,
  output logic        illegal_err,
  output logic        bus_err,
  output lsu_state_e  dbg_state
);

  // Handshakes: an op transfers on a rising edge with start=1 and ready=1;
  // start while ready=0 is dropped. mem_req stays high with stable
  // we/addr/wdata/wstrb until the edge that samples mem_ack=1 (or the timeout),
  // and mem_ack is ignored whenever mem_req is low.
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  lsu_state_e  r_state;
  lsu_err_e    r_err;
  logic        r_is_load;
  logic [2:0]  r_funct3;
  logic [1:0]  r_addr_lo;
  logic [4:0]  r_rd;
  logic [31:0] r_rdata;
  logic [15:0] r_cnt;

  logic        w_illegal;
  logic        w_misalign;
  logic [3:0]  w_strb;
  logic [31:0] w_load_data;

  always_comb begin
    w_illegal  = 1'b0;
    w_misalign = 1'b0;
    if (is_load == is_store) w_illegal = 1'b1;
    else if (is_load)        w_illegal = (funct3 == 3'd3) || (funct3 == 3'd6) || (funct3 == 3'd7);
    else                     w_illegal = (funct3 > F3_W);
    case (funct3[1:0])
      2'd1:    w_misalign = addr[0];
      2'd2:    w_misalign = (addr[1:0] != 2'b00);
      default: w_misalign = 1'b0;
    endcase
  end

  always_comb begin
    w_strb = 4'b0000;
    if (!is_load) begin
      case (funct3[1:0])
        2'd0:    w_strb = STRB_B << addr[1:0];
        2'd1:    w_strb = STRB_H << addr[1:0];
        default: w_strb = STRB_W;
      endcase
    end
  end

  load_align u_load_align (
    .i_mem_rdata (r_rdata),
    .i_addr_lo   (r_addr_lo),
    .i_funct3    (r_funct3),
    .o_data      (w_load_data)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_err        <= ERR_NONE;
      r_is_load    <= 1'b0;
      r_funct3     <= 3'd0;
      r_addr_lo    <= 2'd0;
      r_rd         <= 5'd0;
      r_rdata      <= 32'h0;
      r_cnt        <= 16'd0;
      ready        <= 1'b1;
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= 32'h0;
      mem_wdata    <= 32'h0;
      mem_wstrb    <= 4'b0000;
      wright_reg   <= 5'd0;
      wright_data  <= 32'h0;
      wright_en    <= 1'b0;
      done         <= 1'b0;
      misalign_err <= 1'b0;
      illegal_err  <= 1'b0;
      bus_err      <= 1'b0;
    end else begin
      done         <= 1'b0;
      wright_en    <= 1'b0;
      misalign_err <= 1'b0;
      illegal_err  <= 1'b0;
      bus_err      <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_is_load <= is_load;
            r_funct3  <= funct3;
            r_addr_lo <= addr[1:0];
            r_rd      <= rd;
            r_cnt     <= 16'd0;
            ready     <= 1'b0;
            if (w_illegal) begin
              r_err   <= ERR_ILLEGAL;
              r_state <= ERR;
            end else if (w_misalign) begin
              r_err   <= ERR_MISALIGN;
              r_state <= ERR;
            end else begin
              mem_req   <= 1'b1;
              mem_we    <= ~is_load;
              mem_addr  <= {addr[31:2], 2'b00};
              mem_wdata <= is_load ? 32'h0 : replicate_store(funct3[1:0], store_data);
              mem_wstrb <= w_strb;
              r_state   <= REQ;
            end
          end
        end
        REQ: begin
          r_cnt <= r_cnt + 16'd1;
          if (mem_ack || (r_cnt == TO_LAST)) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 32'h0;
            mem_wdata <= 32'h0;
            mem_wstrb <= 4'b0000;
            // An ack on the timeout edge still completes the op normally.
            if (mem_ack) begin
              r_rdata <= mem_rdata;
              if (r_is_load) begin
                r_state <= WB;
              end else begin
                done    <= 1'b1;
                ready   <= 1'b1;
                r_state <= IDLE;
              end
            end else begin
              r_err   <= ERR_BUS;
              r_state <= ERR;
            end
          end
        end
        WB: begin
          wright_en   <= (r_rd != 5'd0);
          wright_reg  <= r_rd;
          wright_data <= w_load_data;
          done        <= 1'b1;
          ready       <= 1'b1;
          r_state     <= IDLE;
        end
        ERR: begin
          misalign_err <= (r_err == ERR_MISALIGN);
          illegal_err  <= (r_err == ERR_ILLEGAL);
          bus_err      <= (r_err == ERR_BUS);
          done         <= 1'b1;
          ready        <= 1'b1;
          r_state      <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign dbg_state = r_state;

endmodule

// File: tb/tb_lsu_writeback.sv
// Bench for lsu_writeback: directed vector table, randomized ops against a
// behavioural model, plus reset, late-ack and busy-start sequences.
module tb_lsu_writeback;
  import lsu_pkg::*;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        ready;
  logic        is_load = 1'b0;
  logic        is_store = 1'b0;
  logic [2:0]  funct3 = 3'd0;
  logic [31:0] addr = 32'h0;
  logic [31:0] store_data = 32'h0;
  logic [4:0]  rd = 5'd0;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata = 32'h0;
  logic        mem_ack = 1'b0;
  logic [4:0]  wright_reg;
  logic [31:0] wright_data;
  logic        wright_en;
  logic        done;
  logic        misalign_err;
  logic        illegal_err;
  logic        bus_err;
  lsu_state_e  dbg_state;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  lsu_writeback #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .start(start), .ready(ready),
    .is_load(is_load), .is_store(is_store), .funct3(funct3), .addr(addr),
    .store_data(store_data), .rd(rd),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .wright_reg(wright_reg), .wright_data(wright_data), .wright_en(wright_en),
    .done(done), .misalign_err(misalign_err), .illegal_err(illegal_err),
    .bus_err(bus_err), .dbg_state(dbg_state)
  );

  // ---------------- vectors / scoreboard ----------------
  typedef struct {
    logic        is_load;
    logic        is_store;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] sd;
    logic [4:0]  rd;
    logic [31:0] rdata;
    int          dly;
    logic        poke;
    int          e_done_cyc;
    int          e_req_cyc;
    logic        e_mis;
    logic        e_ill;
    logic        e_bus;
    logic        e_wen;
    logic        e_chk_wb;
    logic [31:0] e_wdata;
    logic [31:0] e_maddr;
    logic        e_mwe;
    logic [3:0]  e_strb;
    logic [31:0] e_mwdata;
  } vec_t;

  logic [31:0] exp_q[$];
  vec_t        tbl[$];
  int          n_pass = 0;
  int          n_total = 0;
  string       cur_tag = "init";

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s/%s: got %0h want %0h", cur_tag, name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic outs_nonzero();
    return mem_req | mem_we | (|mem_addr) | (|mem_wdata) | (|mem_wstrb) |
           wright_en | (|wright_reg) | (|wright_data) | done |
           misalign_err | illegal_err | bus_err;
  endfunction

  function automatic vec_t mk_in(input logic ld, input logic st, input logic [2:0] f3,
                                 input logic [31:0] a, input logic [31:0] sd,
                                 input logic [4:0] r, input logic [31:0] rdata,
                                 input int dly, input logic poke);
    vec_t v;
    v.is_load = ld; v.is_store = st; v.f3 = f3; v.addr = a; v.sd = sd;
    v.rd = r; v.rdata = rdata; v.dly = dly; v.poke = poke;
    v.e_done_cyc = 2; v.e_req_cyc = 0;
    v.e_mis = 1'b0; v.e_ill = 1'b0; v.e_bus = 1'b0; v.e_wen = 1'b0;
    v.e_chk_wb = 1'b0; v.e_wdata = 32'h0; v.e_maddr = 32'h0;
    v.e_mwe = 1'b0; v.e_strb = 4'h0; v.e_mwdata = 32'h0;
    return v;
  endfunction

  // Reference model: derives the outcome from the op's rules with arithmetic.
  function automatic vec_t model(input vec_t vin);
    vec_t   v;
    int     nbytes;
    int     lane;
    logic   bad;
    longint val;
    v = mk_in(vin.is_load, vin.is_store, vin.f3, vin.addr, vin.sd, vin.rd,
              vin.rdata, vin.dly, vin.poke);
    lane   = int'(vin.addr % 4);
    nbytes = 1 << (vin.f3 % 4);
    if (vin.is_load == vin.is_store) bad = 1'b1;
    else if (vin.is_load)            bad = !(vin.f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    else                             bad = (vin.f3 > 3'd2);
    if (bad) begin
      v.e_ill = 1'b1;
      return v;
    end
    if ((vin.addr % nbytes) != 0) begin
      v.e_mis = 1'b1;
      return v;
    end
    v.e_maddr = vin.addr - 32'(lane);
    if (vin.dly >= TO) begin
      v.e_req_cyc  = TO;
      v.e_bus      = 1'b1;
      v.e_done_cyc = TO + 2;
    end else begin
      v.e_req_cyc  = vin.dly + 1;
      v.e_done_cyc = vin.dly + (vin.is_load ? 3 : 2);
    end
    if (vin.is_load) begin
      if (!v.e_bus) begin
        val = (longint'(vin.rdata) >> (8 * lane)) % (longint'(1) << (8 * nbytes));
        if (vin.f3 < 3'd2 && val >= (longint'(1) << (8 * nbytes - 1)))
          val = val - (longint'(1) << (8 * nbytes));
        v.e_wdata  = 32'(val);
        v.e_chk_wb = 1'b1;
        v.e_wen    = (vin.rd != 5'd0);
      end
    end else begin
      v.e_mwe  = 1'b1;
      v.e_strb = 4'(((1 << nbytes) - 1) << lane);
      for (int b = 0; b < 4; b++)
        v.e_mwdata[8*b +: 8] = 8'(vin.sd >> (8 * (b % nbytes)));
    end
    return v;
  endfunction

  // ---------------- driver + monitor for one op ----------------
  task automatic run_op(input vec_t v);
    int   req_n = 0, req_bad = 0, wen_n = 0, done_n = 0;
    int   mis_n = 0, ill_n = 0, bus_n = 0, done_at = -1;
    logic [31:0] wd = 32'h0;
    logic [4:0]  wr = 5'd0;
    logic        rdy_at_done = 1'b0;
    if (v.e_chk_wb) exp_q.push_back(v.e_wdata);
    check("ready_before", 32'(ready), 32'd1);
    start = 1'b1; is_load = v.is_load; is_store = v.is_store; funct3 = v.f3;
    addr = v.addr; store_data = v.sd; rd = v.rd;
    step();
    start = 1'b0;
    for (int cyc = 1; cyc <= 20 && done_at < 0; cyc++) begin
      if (mem_req) begin
        req_n++;
        if (mem_addr !== v.e_maddr || mem_we !== v.e_mwe || mem_wstrb !== v.e_strb ||
            (v.e_mwe && mem_wdata !== v.e_mwdata)) req_bad++;
      end
      if (wright_en)    wen_n++;
      if (misalign_err) mis_n++;
      if (illegal_err)  ill_n++;
      if (bus_err)      bus_n++;
      if (done) begin
        done_n++; done_at = cyc; wd = wright_data; wr = wright_reg; rdy_at_done = ready;
      end
      if (v.poke && cyc <= 2) begin
        start = 1'b1; is_load = 1'b0; is_store = 1'b1; funct3 = F3_W; addr = 32'h0;
      end else begin
        start = 1'b0;
      end
      if (mem_req && (req_n - 1) == v.dly) begin
        mem_ack = 1'b1; mem_rdata = v.rdata;
      end else begin
        mem_ack = 1'b0; mem_rdata = $urandom;
      end
      step();
    end
    mem_ack = 1'b0; start = 1'b0;
    if (mem_req)      req_n++;
    if (wright_en)    wen_n++;
    if (misalign_err) mis_n++;
    if (illegal_err)  ill_n++;
    if (bus_err)      bus_n++;
    if (done)         done_n++;
    check("done_cyc", 32'(done_at), 32'(v.e_done_cyc));
    check("done_cnt", 32'(done_n), 32'd1);
    check("req_cycles", 32'(req_n), 32'(v.e_req_cyc));
    check("req_fields", 32'(req_bad), 32'd0);
    check("wen_cnt", 32'(wen_n), 32'(v.e_wen));
    check("misalign_cnt", 32'(mis_n), 32'(v.e_mis));
    check("illegal_cnt", 32'(ill_n), 32'(v.e_ill));
    check("bus_cnt", 32'(bus_n), 32'(v.e_bus));
    check("ready_at_done", 32'(rdy_at_done), 32'd1);
    if (v.e_chk_wb) begin
      check("wright_data", wd, exp_q.pop_front());
      check("wright_reg", 32'(wr), 32'(v.rd));
    end
  endtask

  // ---------------- test ----------------
  initial begin
    vec_t v;
    int   bad;

    // directed table
    v = mk_in(1, 0, F3_B, 32'h1003, 32'h0, 5'd5, 32'h80FF_1234, 0, 0);
    v.e_done_cyc = 3; v.e_req_cyc = 1; v.e_chk_wb = 1; v.e_wdata = 32'hFFFF_FF80;
    v.e_wen = 1; v.e_maddr = 32'h1000; tbl.push_back(v);
    v = mk_in(1, 0, F3_HU, 32'h2002, 32'h0, 5'd7, 32'hBEEF_0000, 0, 0);
    v.e_done_cyc = 3; v.e_req_cyc = 1; v.e_chk_wb = 1; v.e_wdata = 32'h0000_BEEF;
    v.e_wen = 1; v.e_maddr = 32'h2000; tbl.push_back(v);
    v = mk_in(1, 0, F3_H, 32'h2002, 32'h0, 5'd8, 32'hBEEF_0000, 0, 0);
    v.e_done_cyc = 3; v.e_req_cyc = 1; v.e_chk_wb = 1; v.e_wdata = 32'hFFFF_BEEF;
    v.e_wen = 1; v.e_maddr = 32'h2000; tbl.push_back(v);
    v = mk_in(0, 1, F3_B, 32'h3001, 32'h0000_00A5, 5'd0, 32'h0, 0, 0);
    v.e_done_cyc = 2; v.e_req_cyc = 1; v.e_maddr = 32'h3000; v.e_mwe = 1;
    v.e_strb = 4'b0010; v.e_mwdata = 32'hA5A5_A5A5; tbl.push_back(v);
    v = mk_in(1, 0, F3_W, 32'h4002, 32'h0, 5'd1, 32'h0, 0, 0);
    v.e_mis = 1; tbl.push_back(v);
    v = mk_in(1, 0, 3'd3, 32'h5000, 32'h0, 5'd1, 32'h0, 0, 0);
    v.e_ill = 1; tbl.push_back(v);
    v = mk_in(1, 0, F3_W, 32'h6000, 32'h0, 5'd4, 32'h1111_2222, 10, 0);
    v.e_bus = 1; v.e_req_cyc = 4; v.e_done_cyc = 6; v.e_maddr = 32'h6000; tbl.push_back(v);
    v = mk_in(0, 1, F3_W, 32'h7000, 32'h1234_5678, 5'd0, 32'h0, 2, 0);
    v.e_done_cyc = 4; v.e_req_cyc = 3; v.e_maddr = 32'h7000; v.e_mwe = 1;
    v.e_strb = 4'b1111; v.e_mwdata = 32'h1234_5678; tbl.push_back(v);
    v = mk_in(0, 1, F3_H, 32'h7002, 32'hCAFE_BEEF, 5'd0, 32'h0, 1, 0);
    v.e_done_cyc = 3; v.e_req_cyc = 2; v.e_maddr = 32'h7000; v.e_mwe = 1;
    v.e_strb = 4'b1100; v.e_mwdata = 32'hBEEF_BEEF; tbl.push_back(v);
    v = mk_in(1, 1, F3_W, 32'h0, 32'h0, 5'd1, 32'h0, 0, 0);
    v.e_ill = 1; tbl.push_back(v);
    v = mk_in(0, 0, F3_W, 32'h0, 32'h0, 5'd1, 32'h0, 0, 0);
    v.e_ill = 1; tbl.push_back(v);
    v = mk_in(0, 1, 3'd4, 32'h0, 32'h0, 5'd1, 32'h0, 0, 0);
    v.e_ill = 1; tbl.push_back(v);
    v = mk_in(1, 0, F3_BU, 32'h8001, 32'h0, 5'd10, 32'h1234_80AB, 3, 0);
    v.e_done_cyc = 6; v.e_req_cyc = 4; v.e_chk_wb = 1; v.e_wdata = 32'h0000_0080;
    v.e_wen = 1; v.e_maddr = 32'h8000; tbl.push_back(v);
    v = mk_in(1, 0, F3_W, 32'h9000, 32'h0, 5'd0, 32'hDEAD_BEEF, 0, 0);
    v.e_done_cyc = 3; v.e_req_cyc = 1; v.e_chk_wb = 1; v.e_wdata = 32'hDEAD_BEEF;
    v.e_wen = 0; v.e_maddr = 32'h9000; tbl.push_back(v);
    v = mk_in(0, 1, F3_H, 32'hA001, 32'h0, 5'd0, 32'h0, 0, 0);
    v.e_mis = 1; tbl.push_back(v);
    v = mk_in(1, 0, F3_W, 32'hB000, 32'h0, 5'd9, 32'h0BAD_F00D, 1, 1);
    v.e_done_cyc = 4; v.e_req_cyc = 2; v.e_chk_wb = 1; v.e_wdata = 32'h0BAD_F00D;
    v.e_wen = 1; v.e_maddr = 32'hB000; tbl.push_back(v);
    v = mk_in(1, 0, F3_B, 32'hC002, 32'h0, 5'd31, 32'h007F_0000, 0, 0);
    v.e_done_cyc = 3; v.e_req_cyc = 1; v.e_chk_wb = 1; v.e_wdata = 32'h0000_007F;
    v.e_wen = 1; v.e_maddr = 32'hC000; tbl.push_back(v);

    // reset
    cur_tag = "reset";
    rst = 1'b0;
    repeat (3) step();
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_outputs_zero", 32'(outs_nonzero()), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(IDLE));
    rst = 1'b1;
    step();

    for (int i = 0; i < tbl.size(); i++) begin
      cur_tag = $sformatf("tbl%0d", i);
      run_op(tbl[i]);
    end

    // late ack after a timeout is ignored
    cur_tag = "late_ack";
    run_op(tbl[6]);
    bad = 0;
    for (int c = 0; c < 3; c++) begin
      mem_ack = 1'b1; mem_rdata = $urandom;
      step();
      if (done || wright_en || mem_req || bus_err || !ready) bad++;
    end
    mem_ack = 1'b0;
    step();
    if (done || wright_en || mem_req || !ready) bad++;
    check("late_ack_ignored", 32'(bad), 32'd0);

    // asynchronous reset in the middle of REQ
    cur_tag = "mid_reset";
    start = 1'b1; is_load = 1'b1; is_store = 1'b0; funct3 = F3_W;
    addr = 32'hD000; rd = 5'd3;
    step();
    start = 1'b0;
    step();
    check("in_req", 32'(mem_req), 32'd1);
    #2 rst = 1'b0;
    #1;
    check("async_ready", 32'(ready), 32'd1);
    check("async_zero", 32'(outs_nonzero()), 32'd0);
    @(posedge clk);
    #1 rst = 1'b1;
    bad = 0;
    for (int c = 0; c < 6; c++) begin
      mem_ack = (c == 1); mem_rdata = $urandom;
      step();
      if (wright_en || done || mem_req || !ready) bad++;
    end
    mem_ack = 1'b0;
    check("post_reset_quiet", 32'(bad), 32'd0);
    v = model(mk_in(1, 0, F3_W, 32'hE000, 32'h0, 5'd0, 32'h5555_AAAA, 0, 0));
    run_op(v);

    // randomized ops against the model
    for (int i = 0; i < 200; i++) begin
      logic [1:0] lo;
      cur_tag = $sformatf("rnd%0d", i);
      v = mk_in(0, 0, 3'd0, 32'h0, 32'h0, 5'd0, 32'h0, 0, 0);
      v.is_load  = 1'($urandom_range(0, 1));
      v.is_store = !v.is_load;
      if ($urandom_range(0, 15) == 0) v.is_store = v.is_load;
      if ($urandom_range(0, 4) == 0)  v.f3 = 3'($urandom_range(0, 7));
      else if (v.is_load) begin
        case ($urandom_range(0, 4))
          0: v.f3 = F3_B;  1: v.f3 = F3_H;  2: v.f3 = F3_W;
          3: v.f3 = F3_BU; default: v.f3 = F3_HU;
        endcase
      end else v.f3 = 3'($urandom_range(0, 2));
      lo = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) != 0) begin
        if (v.f3[1:0] == 2'd1)      lo[0] = 1'b0;
        else if (v.f3[1:0] == 2'd2) lo = 2'b00;
      end
      v.addr = $urandom;
      v.addr[1:0] = lo;
      v.sd    = $urandom;
      v.rdata = $urandom;
      v.rd    = 5'($urandom_range(0, 31));
      v.dly   = $urandom_range(0, 5);
      run_op(model(v));
    end

    cur_tag = "final";
    check("exp_q_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
